// File: rtl/mips_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// mips_ctrl_pkg
//
// Shared types for the multicycle MIPS control FSM:
//   - state_e      : FSM state encoding (4 bits)
//   - OP_*         : primary opcode values (IR[31:26])
//   - alu_op_e     : ALU operation select
//   - alu_src_b_e  : ALU B operand select
//   - pc_src_e     : PC source select
//   - ctrl_t       : control word bundling every controller output except state
//   - op_is_legal(): true for opcodes the controller can sequence
//
// Optional feature macro: MC_BNE_EN (adds BNE, opcode 000101, as a legal op).
// ---------------------------------------------------------------------------
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWB  = 4'd5,
    S_MEMWR  = 4'd6,
    S_EXEC   = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9,
    S_ADDIEX = 4'd10,
    S_ADDIWB = 4'd11,
    S_JUMP   = 4'd12
  } state_e;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;

  typedef enum logic [1:0] {
    ALU_ADD   = 2'b00,
    ALU_SUB   = 2'b01,
    ALU_FUNCT = 2'b10
  } alu_op_e;

  typedef enum logic [1:0] {
    SRCB_REG     = 2'b00,
    SRCB_FOUR    = 2'b01,
    SRCB_IMM     = 2'b10,
    SRCB_IMM_SH2 = 2'b11
  } alu_src_b_e;

  typedef enum logic [1:0] {
    PC_ALU    = 2'b00,
    PC_ALUOUT = 2'b01,
    PC_JUMP   = 2'b10
  } pc_src_e;

  typedef struct packed {
    logic       mem_req;
    logic       iord;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    alu_src_b_e alu_src_b;
    alu_op_e    alu_op;
    pc_src_e    pc_src;
    logic       pc_en;
    logic       illegal_op;
  } ctrl_t;

  // All strobes low, all selects at their 00 encoding.
  localparam ctrl_t CTRL_NONE = '0;

  function automatic logic op_is_legal(input logic [5:0] op);
    logic legal;
    case (op)
      OP_R, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J: legal = 1'b1;
`ifdef MC_BNE_EN
      OP_BNE:                                    legal = 1'b1;
`endif
      default:                                   legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/mc_output_decode.sv
// ---------------------------------------------------------------------------
// mc_output_decode
//
// Combinational map from the current FSM state to the datapath control word.
// Outputs are Moore except the handshake-qualified strobes: ir_write/pc_en in
// S_FETCH follow mem_ready, and pc_en in S_BRANCH follows zero (inverted for
// a BNE branch sense).
//
// Ports:
//   state     in  current FSM state
//   mem_ready in  memory completes the current access this cycle
//   zero      in  ALU zero flag
//   branch_ne in  registered branch sense (1 = BNE), 0 when BNE is not built
//   op_legal  in  opcode is decodable (only consulted in S_DECODE)
//   ctrl      out control word
// ---------------------------------------------------------------------------
module mc_output_decode
  import mips_ctrl_pkg::*;
(
  input  state_e state,
  input  logic   mem_ready,
  input  logic   zero,
  input  logic   branch_ne,
  input  logic   op_legal,
  output ctrl_t  ctrl
);

  always_comb begin
    // NOTE: every field gets a default before the case so no path leaves a
    // bit unassigned, which would otherwise infer a latch.
    ctrl = CTRL_NONE;
    case (state)
      S_FETCH: begin
        ctrl.mem_req   = 1'b1;
        ctrl.iord      = 1'b0;
        ctrl.alu_src_a = 1'b0;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu_op    = ALU_ADD;
        ctrl.pc_src    = PC_ALU;
        ctrl.ir_write  = mem_ready;
        ctrl.pc_en     = mem_ready;
      end
      S_DECODE: begin
        // Precompute the branch target while the opcode is decoded.
        ctrl.alu_src_a  = 1'b0;
        ctrl.alu_src_b  = SRCB_IMM_SH2;
        ctrl.alu_op     = ALU_ADD;
        ctrl.illegal_op = ~op_legal;
      end
      S_MEMADR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALU_ADD;
      end
      S_MEMRD: begin
        ctrl.mem_req = 1'b1;
        ctrl.iord    = 1'b1;
      end
      S_MEMWB: begin
        ctrl.reg_dst    = 1'b0;
        ctrl.mem_to_reg = 1'b1;
        ctrl.reg_write  = 1'b1;
      end
      S_MEMWR: begin
        ctrl.mem_req   = 1'b1;
        ctrl.iord      = 1'b1;
        ctrl.mem_write = 1'b1;
      end
      S_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_REG;
        ctrl.alu_op    = ALU_FUNCT;
      end
      S_ALUWB: begin
        ctrl.reg_dst    = 1'b1;
        ctrl.mem_to_reg = 1'b0;
        ctrl.reg_write  = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_REG;
        ctrl.alu_op    = ALU_SUB;
        ctrl.pc_src    = PC_ALUOUT;
        ctrl.pc_en     = branch_ne ? ~zero : zero;
      end
      S_ADDIEX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALU_ADD;
      end
      S_ADDIWB: begin
        ctrl.reg_dst    = 1'b0;
        ctrl.mem_to_reg = 1'b0;
        ctrl.reg_write  = 1'b1;
      end
      S_JUMP: begin
        ctrl.pc_src = PC_JUMP;
        ctrl.pc_en  = 1'b1;
      end
      // S_IDLE and unused encodings drive the all-zero word.
      default: ctrl = CTRL_NONE;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// ---------------------------------------------------------------------------
// multicycle_controller
//
// Main control FSM for the multicycle MIPS datapath. Sequences the shared ALU,
// the unified memory port (req/ready handshake), IR, register file and PC.
// The state register resets asynchronously, so every strobe decoded from it
// drops the moment rst falls.
//
// Ports:
//   clk        in   clock, rising edge
//   rst        in   asynchronous active-low reset
//   opcode     in   IR[31:26]
//   zero       in   ALU zero flag
//   mem_ready  in   memory completes the current access this cycle
//   mem_req    out  memory access request
//   iord       out  memory address select (0 = PC, 1 = ALUOut)
//   mem_write  out  store strobe
//   ir_write   out  IR load enable
//   reg_dst    out  write register select (0 = rt, 1 = rd)
//   mem_to_reg out  write data select (0 = ALUOut, 1 = MDR)
//   reg_write  out  register file write enable
//   alu_src_a  out  ALU A select (0 = PC, 1 = A)
//   alu_src_b  out  ALU B select (B, 4, imm, imm<<2)
//   alu_op     out  00 add, 01 sub, 10 funct
//   pc_src     out  00 ALU, 01 ALUOut, 10 jump target
//   pc_en      out  PC load enable
//   illegal_op out  one-cycle pulse on an undecodable opcode
//   state      out  current state (debug)
//
// Optional feature macro: MC_BNE_EN (BNE decodes to S_BRANCH with inverted
// zero sense; otherwise opcode 000101 is illegal).
// ---------------------------------------------------------------------------
module multicycle_controller
  import mips_ctrl_pkg::*;
#(
  parameter int OP_W    = 6,
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [OP_W-1:0]    opcode,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               mem_req,
  output logic               iord,
  output logic               mem_write,
  output logic               ir_write,
  output logic               reg_dst,
  output logic               mem_to_reg,
  output logic               reg_write,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [1:0]         alu_op,
  output logic [1:0]         pc_src,
  output logic               pc_en,
  output logic               illegal_op,
  output logic [STATE_W-1:0] state
);

  state_e state_q, state_d;
  logic   op_legal;
  logic   branch_ne;
  ctrl_t  ctrl;

  assign op_legal = op_is_legal(opcode);

  // ---------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   state_d = S_FETCH;
      S_FETCH:  if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXEC;
          OP_BEQ:       state_d = S_BRANCH;
`ifdef MC_BNE_EN
          OP_BNE:       state_d = S_BRANCH;
`endif
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JUMP;
          // Illegal opcode: executes as a NOP, PC already advanced in fetch.
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR: state_d = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  if (mem_ready) state_d = S_MEMWB;
      S_MEMWB:  state_d = S_FETCH;
      S_MEMWR:  if (mem_ready) state_d = S_FETCH;
      S_EXEC:   state_d = S_ALUWB;
      S_ALUWB:  state_d = S_FETCH;
      S_BRANCH: state_d = S_FETCH;
      S_ADDIEX: state_d = S_ADDIWB;
      S_ADDIWB: state_d = S_FETCH;
      S_JUMP:   state_d = S_FETCH;
      // Unused encodings recover exactly like S_IDLE.
      default:  state_d = S_FETCH;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples its pre-edge inputs regardless of block ordering.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // ---------------------------------------------------------------------
  // Branch sense: captured in S_DECODE, consumed in S_BRANCH.
  // ---------------------------------------------------------------------
`ifdef MC_BNE_EN
  logic bne_q, bne_d;

  always_comb begin
    bne_d = bne_q;
    if (state_q == S_DECODE) bne_d = (opcode == OP_BNE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) bne_q <= 1'b0;
    else      bne_q <= bne_d;
  end

  assign branch_ne = bne_q;
`else
  assign branch_ne = 1'b0;
`endif

  // ---------------------------------------------------------------------
  // Output decode
  // ---------------------------------------------------------------------
  mc_output_decode u_output_decode (
    .state     (state_q),
    .mem_ready (mem_ready),
    .zero      (zero),
    .branch_ne (branch_ne),
    .op_legal  (op_legal),
    .ctrl      (ctrl)
  );

  assign mem_req    = ctrl.mem_req;
  assign iord       = ctrl.iord;
  assign mem_write  = ctrl.mem_write;
  assign ir_write   = ctrl.ir_write;
  assign reg_dst    = ctrl.reg_dst;
  assign mem_to_reg = ctrl.mem_to_reg;
  assign reg_write  = ctrl.reg_write;
  assign alu_src_a  = ctrl.alu_src_a;
  assign alu_src_b  = ctrl.alu_src_b;
  assign alu_op     = ctrl.alu_op;
  assign pc_src     = ctrl.pc_src;
  assign pc_en      = ctrl.pc_en;
  assign illegal_op = ctrl.illegal_op;
  assign state      = STATE_W'(state_q);

endmodule

// File: tb/tb_multicycle_controller.sv
// ---------------------------------------------------------------------------
// tb_multicycle_controller
//
// Directed testbench for multicycle_controller. Each task drives one
// instruction scenario and compares outputs against hand-computed values.
// Inputs change 1 time unit after the rising edge; outputs are compared
// before the next rising edge.
// ---------------------------------------------------------------------------
module tb_multicycle_controller;
  import mips_ctrl_pkg::*;

  logic       clk;
  logic       rst;
  logic [5:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic       mem_req, iord, mem_write, ir_write, reg_dst, mem_to_reg;
  logic       reg_write, alu_src_a, pc_en, illegal_op;
  logic [1:0] alu_src_b, alu_op, pc_src;
  logic [3:0] state;

  int n_checks = 0;
  int n_fail   = 0;

  multicycle_controller #(.OP_W(6), .STATE_W(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .opcode     (opcode),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .mem_req    (mem_req),
    .iord       (iord),
    .mem_write  (mem_write),
    .ir_write   (ir_write),
    .reg_dst    (reg_dst),
    .mem_to_reg (mem_to_reg),
    .reg_write  (reg_write),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .alu_op     (alu_op),
    .pc_src     (pc_src),
    .pc_en      (pc_en),
    .illegal_op (illegal_op),
    .state      (state)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // All outputs except state, packed for "everything is zero" comparisons.
  function automatic logic [15:0] all_ctrl();
    return {mem_req, iord, mem_write, ir_write, reg_dst, mem_to_reg,
            reg_write, alu_src_a, alu_src_b, alu_op, pc_src, pc_en, illegal_op};
  endfunction

  // -------------------------------------------------------------------------
  task automatic test_reset();
    rst = 1'b0; opcode = OP_LW; zero = 1'b0; mem_ready = 1'b1;
    #2;
    n_checks++;
    if (state !== S_IDLE) begin
      n_fail++; $display("FAIL reset_state: got %0d expected %0d", state, S_IDLE);
    end
    tick();
    n_checks++;
    if ({state, all_ctrl()} !== 20'h0) begin
      n_fail++; $display("FAIL reset_outputs: got %h expected 00000", {state, all_ctrl()});
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if (state !== S_IDLE) begin
      n_fail++; $display("FAIL reset_release_hold: got %0d expected %0d", state, S_IDLE);
    end
  endtask

  // -------------------------------------------------------------------------
  // LW with mem_ready tied high; starts in S_IDLE.
  task automatic test_lw();
    state_e     exp_st [6] = '{S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_FETCH};
    logic [2:0] exp_ctl[6] = '{3'b001, 3'b000, 3'b000, 3'b000, 3'b110, 3'b001};
    opcode = OP_LW; mem_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      n_checks++;
      if ({state, reg_write, mem_to_reg, pc_en} !== {exp_st[i], exp_ctl[i]}) begin
        n_fail++;
        $display("FAIL lw_step%0d: got state=%0d rw/m2r/pcen=%b expected state=%0d rw/m2r/pcen=%b",
                 i, state, {reg_write, mem_to_reg, pc_en}, exp_st[i], exp_ctl[i]);
      end
    end
  endtask

  // -------------------------------------------------------------------------
  // Fetch wait state then an R-type instruction; starts in S_FETCH.
  task automatic test_fetch_wait_r();
    opcode = OP_R; mem_ready = 1'b0;
    #1;
    n_checks++;
    if ({mem_req, iord, ir_write, pc_en} !== 4'b1000) begin
      n_fail++; $display("FAIL fetch_wait_strobes: got %b expected 1000", {mem_req, iord, ir_write, pc_en});
    end
    tick();
    n_checks++;
    if (state !== S_FETCH) begin
      n_fail++; $display("FAIL fetch_wait_hold: got %0d expected %0d", state, S_FETCH);
    end
    mem_ready = 1'b1;
    #1;
    n_checks++;
    if ({ir_write, pc_en, alu_src_b, pc_src} !== 6'b11_01_00) begin
      n_fail++; $display("FAIL fetch_ready: got %b expected 110100", {ir_write, pc_en, alu_src_b, pc_src});
    end
    tick(); // DECODE
    tick(); // EXEC
    n_checks++;
    if ({state, alu_src_a, alu_src_b, alu_op} !== {S_EXEC, 1'b1, 2'b00, 2'b10}) begin
      n_fail++; $display("FAIL r_exec: got %h expected %h", {state, alu_src_a, alu_src_b, alu_op},
                         {S_EXEC, 1'b1, 2'b00, 2'b10});
    end
    tick(); // ALUWB
    n_checks++;
    if ({state, reg_dst, mem_to_reg, reg_write} !== {S_ALUWB, 3'b101}) begin
      n_fail++; $display("FAIL r_aluwb: got %h expected %h", {state, reg_dst, mem_to_reg, reg_write},
                         {S_ALUWB, 3'b101});
    end
    tick(); // FETCH
  endtask

  // -------------------------------------------------------------------------
  // SW with three wait cycles in S_MEMWR; starts in S_FETCH.
  task automatic test_sw_wait();
    int wr_cycles = 0;
    opcode = OP_SW; mem_ready = 1'b1;
    tick(); // DECODE
    mem_ready = 1'b0; // ignored outside fetch/memory states
    #1;
    n_checks++;
    if ({state, alu_src_a, alu_src_b} !== {S_DECODE, 1'b0, 2'b11}) begin
      n_fail++; $display("FAIL sw_decode: got %h expected %h", {state, alu_src_a, alu_src_b}, {S_DECODE, 3'b011});
    end
    tick(); // MEMADR
    n_checks++;
    if ({state, alu_src_a, alu_src_b} !== {S_MEMADR, 1'b1, 2'b10}) begin
      n_fail++; $display("FAIL sw_memadr: got %h expected %h", {state, alu_src_a, alu_src_b}, {S_MEMADR, 3'b110});
    end
    tick(); // MEMWR
    for (int i = 0; i < 3; i++) begin
      if (state == S_MEMWR && mem_write && mem_req && iord) wr_cycles++;
      tick();
    end
    mem_ready = 1'b1;
    #1;
    if (state == S_MEMWR && mem_write && mem_req && iord) wr_cycles++;
    n_checks++;
    if (wr_cycles != 4) begin
      n_fail++; $display("FAIL sw_write_cycles: got %0d expected 4", wr_cycles);
    end
    tick();
    n_checks++;
    if ({state, mem_write} !== {S_FETCH, 1'b0}) begin
      n_fail++; $display("FAIL sw_return: got state=%0d mem_write=%b expected state=%0d mem_write=0",
                         state, mem_write, S_FETCH);
    end
  endtask

  // -------------------------------------------------------------------------
  // BEQ taken then not taken; starts in S_FETCH.
  task automatic test_beq();
    opcode = OP_BEQ; mem_ready = 1'b1; zero = 1'b1;
    tick(); tick();
    n_checks++;
    if ({state, pc_en, pc_src, alu_op} !== {S_BRANCH, 1'b1, 2'b01, 2'b01}) begin
      n_fail++; $display("FAIL beq_taken: got %h expected %h", {state, pc_en, pc_src, alu_op},
                         {S_BRANCH, 5'b10101});
    end
    tick();
    n_checks++;
    if (state !== S_FETCH) begin
      n_fail++; $display("FAIL beq_return: got %0d expected %0d", state, S_FETCH);
    end
    zero = 1'b0;
    tick(); tick();
    n_checks++;
    if ({state, pc_en, pc_src} !== {S_BRANCH, 1'b0, 2'b01}) begin
      n_fail++; $display("FAIL beq_not_taken: got %h expected %h", {state, pc_en, pc_src}, {S_BRANCH, 3'b001});
    end
    tick();
  endtask

  // -------------------------------------------------------------------------
  // ADDI and J datapath controls; starts in S_FETCH.
  task automatic test_addi_j();
    opcode = OP_ADDI; mem_ready = 1'b1; zero = 1'b0;
    tick(); tick();
    n_checks++;
    if ({state, alu_src_a, alu_src_b, alu_op} !== {S_ADDIEX, 1'b1, 2'b10, 2'b00}) begin
      n_fail++; $display("FAIL addi_ex: got %h expected %h", {state, alu_src_a, alu_src_b, alu_op},
                         {S_ADDIEX, 5'b11000});
    end
    tick();
    n_checks++;
    if ({state, reg_dst, mem_to_reg, reg_write} !== {S_ADDIWB, 3'b001}) begin
      n_fail++; $display("FAIL addi_wb: got %h expected %h", {state, reg_dst, mem_to_reg, reg_write},
                         {S_ADDIWB, 3'b001});
    end
    tick();
    opcode = OP_J;
    tick(); tick();
    n_checks++;
    if ({state, pc_src, pc_en, reg_write, mem_write} !== {S_JUMP, 2'b10, 3'b100}) begin
      n_fail++; $display("FAIL jump: got %h expected %h", {state, pc_src, pc_en, reg_write, mem_write},
                         {S_JUMP, 5'b10100});
    end
    tick();
  endtask

  // -------------------------------------------------------------------------
  // Undecodable opcode; starts in S_FETCH.
  task automatic test_illegal();
    opcode = 6'b111111; mem_ready = 1'b1;
    tick();
    n_checks++;
    if ({state, illegal_op, reg_write, mem_write} !== {S_DECODE, 3'b100}) begin
      n_fail++; $display("FAIL illegal_decode: got %h expected %h", {state, illegal_op, reg_write, mem_write},
                         {S_DECODE, 3'b100});
    end
    tick();
    n_checks++;
    if ({state, illegal_op, reg_write, mem_write} !== {S_FETCH, 3'b000}) begin
      n_fail++; $display("FAIL illegal_next: got %h expected %h", {state, illegal_op, reg_write, mem_write},
                         {S_FETCH, 3'b000});
    end
  endtask

  // -------------------------------------------------------------------------
  // Opcode 000101: BNE when built with the option, illegal otherwise.
  task automatic test_bne();
    opcode = 6'b000101; mem_ready = 1'b1; zero = 1'b0;
    tick();
`ifdef MC_BNE_EN
    n_checks++;
    if (illegal_op !== 1'b0) begin
      n_fail++; $display("FAIL bne_decode_legal: got illegal_op=%b expected 0", illegal_op);
    end
    tick();
    n_checks++;
    if ({state, pc_en, pc_src} !== {S_BRANCH, 1'b1, 2'b01}) begin
      n_fail++; $display("FAIL bne_taken: got %h expected %h", {state, pc_en, pc_src}, {S_BRANCH, 3'b101});
    end
    tick();
    zero = 1'b1;
    tick(); tick();
    n_checks++;
    if ({state, pc_en} !== {S_BRANCH, 1'b0}) begin
      n_fail++; $display("FAIL bne_not_taken: got %h expected %h", {state, pc_en}, {S_BRANCH, 1'b0});
    end
    tick();
    opcode = OP_BEQ; // branch sense must return to BEQ
    tick(); tick();
    n_checks++;
    if ({state, pc_en} !== {S_BRANCH, 1'b1}) begin
      n_fail++; $display("FAIL bne_then_beq: got %h expected %h", {state, pc_en}, {S_BRANCH, 1'b1});
    end
    tick();
`else
    n_checks++;
    if ({state, illegal_op} !== {S_DECODE, 1'b1}) begin
      n_fail++; $display("FAIL bne_illegal: got %h expected %h", {state, illegal_op}, {S_DECODE, 1'b1});
    end
    tick();
    n_checks++;
    if (state !== S_FETCH) begin
      n_fail++; $display("FAIL bne_illegal_next: got %0d expected %0d", state, S_FETCH);
    end
`endif
    zero = 1'b0;
  endtask

  // -------------------------------------------------------------------------
  // Zero-wait cycle counts from FETCH back to FETCH; starts in S_FETCH.
  task automatic test_cycle_counts();
    logic [5:0] ops [6] = '{OP_LW, OP_SW, OP_R, OP_ADDI, OP_BEQ, OP_J};
    int         exp_n[6] = '{5, 4, 4, 4, 3, 3};
    int         n;
    mem_ready = 1'b1; zero = 1'b0;
    for (int k = 0; k < 6; k++) begin
      opcode = ops[k];
      n = 1;
      tick();
      while (state != S_FETCH && n < 20) begin
        n++;
        tick();
      end
      n_checks++;
      if (n != exp_n[k]) begin
        n_fail++; $display("FAIL cycles_op%b: got %0d expected %0d", ops[k], n, exp_n[k]);
      end
    end
  endtask

  // -------------------------------------------------------------------------
  // Asynchronous reset while a store is in progress; starts in S_FETCH.
  task automatic test_reset_mid_store();
    opcode = OP_SW; mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    tick(); tick(); // MEMADR, MEMWR
    n_checks++;
    if ({state, mem_write, mem_req} !== {S_MEMWR, 2'b11}) begin
      n_fail++; $display("FAIL rst_mid_pre: got %h expected %h", {state, mem_write, mem_req}, {S_MEMWR, 2'b11});
    end
    #2;
    rst = 1'b0;
    #1; // still well before the next rising edge
    n_checks++;
    if ({state, all_ctrl()} !== 20'h0) begin
      n_fail++; $display("FAIL rst_mid_async: got %h expected 00000", {state, all_ctrl()});
    end
    mem_ready = 1'b1;
    tick();
    n_checks++;
    if (state !== S_IDLE) begin
      n_fail++; $display("FAIL rst_mid_hold: got %0d expected %0d", state, S_IDLE);
    end
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if ({state, all_ctrl()} !== 20'h0) begin
      n_fail++; $display("FAIL rst_mid_release: got %h expected 00000", {state, all_ctrl()});
    end
    tick();
    n_checks++;
    if (state !== S_FETCH) begin
      n_fail++; $display("FAIL rst_mid_first_edge: got %0d expected %0d", state, S_FETCH);
    end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_fetch_wait_r();
    test_sw_wait();
    test_beq();
    test_addi_j();
    test_illegal();
    test_bne();
    test_cycle_counts();
    test_reset_mid_store();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Main control FSM for the multicycle MIPS datapath.
- Sequences the shared ALU, the single unified instruction/data memory port, the IR, the register file and the PC across 3-5 states per instruction.
- Sits beside the datapath and drives its mux selects (mux2/mux4), enables and write strobes.
- Memory accesses use a req/ready handshake so that wait states are tolerated.

Parameters:
- OP_W, 6, opcode field width.
- STATE_W, 4, state register width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- opcode  in  OP_W  IR[31:26].
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory completes the current access this cycle.
- mem_req  out  1  memory access request.
- iord  out  1  memory address select: 0 = PC, 1 = ALUOut.
- mem_write  out  1  store strobe.
- ir_write  out  1  IR load enable.
- reg_dst  out  1  write register select: 0 = rt, 1 = rd.
- mem_to_reg  out  1  write data select: 0 = ALUOut, 1 = MDR.
- reg_write  out  1  register file write enable.
- alu_src_a  out  1  ALU A select: 0 = PC, 1 = A register.
- alu_src_b  out  2  ALU B select: 00 = B, 01 = 4, 10 = sign-extended imm, 11 = sign-extended imm shifted left 2.
- alu_op  out  2  00 = add, 01 = sub, 10 = decode funct.
- pc_src  out  2  PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- pc_en  out  1  PC load enable.
- illegal_op  out  1  one-cycle pulse on an undecodable opcode.
- state  out  STATE_W  current state, for debug.

Behaviour:
- Reset: rst low asynchronously forces state to S_IDLE. In S_IDLE every output is 0. The FSM always moves from S_IDLE to S_FETCH on the next edge.
- Outputs are Moore, except that the handshake-qualified strobes include mem_ready combinationally (noted below).
- Opcodes: R = 000000, LW = 100011, SW = 101011, BEQ = 000100, ADDI = 001000, J = 000010.
- S_FETCH:
  - Drives mem_req=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_src=00.
  - ir_write = pc_en = mem_ready.
  - Holds in S_FETCH while mem_ready=0; moves to S_DECODE on mem_ready=1.
- S_DECODE:
  - Drives alu_src_a=0, alu_src_b=11, alu_op=00 (branch target precompute).
  - Next state: LW/SW -> S_MEMADR, R -> S_EXEC, BEQ -> S_BRANCH, ADDI -> S_ADDIEX, J -> S_JUMP.
  - Any other opcode: illegal_op=1 for this cycle, then -> S_FETCH. The instruction executes as a NOP; the PC is already advanced.
- S_MEMADR: alu_src_a=1, alu_src_b=10, alu_op=00. LW -> S_MEMRD, SW -> S_MEMWR.
- S_MEMRD: mem_req=1, iord=1. Holds until mem_ready=1, then -> S_MEMWB.
- S_MEMWB: reg_dst=0, mem_to_reg=1, reg_write=1. -> S_FETCH.
- S_MEMWR:
  - mem_req=1, iord=1, mem_write=1.
  - mem_write stays high until the mem_ready cycle, then -> S_FETCH.
- S_EXEC: alu_src_a=1, alu_src_b=00, alu_op=10. -> S_ALUWB.
- S_ALUWB: reg_dst=1, mem_to_reg=0, reg_write=1. -> S_FETCH.
- S_BRANCH:
  - alu_src_a=1, alu_src_b=00, alu_op=01, pc_src=01.
  - pc_en = zero (combinational).
  - -> S_FETCH.
- S_ADDIEX: alu_src_a=1, alu_src_b=10, alu_op=00. -> S_ADDIWB.
- S_ADDIWB: reg_dst=0, mem_to_reg=0, reg_write=1. -> S_FETCH.
- S_JUMP: pc_src=10, pc_en=1. -> S_FETCH.
- Outputs not listed for a state are 0.
- Unreachable state encodings behave as S_IDLE.
- Reset mid-instruction: all strobes drop immediately, asynchronously. No partial write may occur after rst falls.
- mem_ready outside S_FETCH, S_MEMRD and S_MEMWR is ignored.
- Cycle counts with zero wait states:
  - LW 5, SW 4, R 4, ADDI 4, BEQ 3, J 3.
  - Each memory wait cycle adds 1.

Optional Feature:
- Macro MC_BNE_EN.
- Defined: opcode 000101 (BNE) decodes to S_BRANCH. In S_BRANCH, pc_en = ~zero for BNE and pc_en = zero for BEQ. The last decoded branch sense is held in a 1-bit register captured in S_DECODE.
- Undefined: 000101 is illegal (illegal_op pulse, NOP).

Decomposition:
- Package mips_ctrl_pkg holds:
  - state enum (S_IDLE … S_JUMP, 4-bit);
  - opcode localparams;
  - alu_op, alu_src_b and pc_src encodings as enums;
  - a control-word struct bundling all outputs except state.
- One natural sub-module: mc_output_decode, a combinational map from state, mem_ready, zero and the branch-sense bit to the control word.
- State register and next-state logic stay in the top module.

Test Plan:
- Reset then LW with mem_ready tied 1:
  - state sequence IDLE, FETCH, DECODE, MEMADR, MEMRD, MEMWB, FETCH;
  - reg_write=1 and mem_to_reg=1 only in MEMWB;
  - pc_en=1 only in the FETCH cycle.
- SW with mem_ready low for 3 cycles in MEMWR:
  - mem_write high for 4 consecutive cycles;
  - FSM returns to FETCH on the cycle after mem_ready=1.
- BEQ with zero=1, then BEQ with zero=0:
  - pc_en=1 with pc_src=01 in the first BRANCH cycle;
  - pc_en=0 in the second.
- Opcode 111111:
  - illegal_op pulses 1 in DECODE;
  - next state FETCH;
  - no reg_write or mem_write asserted.
- rst driven low during S_MEMWR with mem_write=1:
  - mem_write and mem_req fall in the same cycle, without waiting for a clock;
  - state=S_IDLE until the first edge after rst returns high.
- MC_BNE_EN defined, opcode 000101 with zero=0: pc_en=1 in BRANCH. Macro undefined: illegal_op=1 instead.
